aos_mem2strm: RTL and testbench

Multi-channel bridge between the single-port memory request interface produced by `axi_mem_if_SP_wrap` and the streaming inputs of AOS accelerator cores. It replaces the single-channel, handshake-less hookup with the following:
- `NUM_CH` independent channels.
- A per-channel write FIFO with real `valid`/`ready` backpressure.
- A last/keep side-band driven by address decode.
- A captured result register per channel.
- A status/control register set.

---
 rtl/aos_mem2strm.sv | 213 +++++++++++++++++++++
 tb/tb_aos_mem2strm.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aos_mem2strm.sv
// aos_mem2strm -- bridge from a single-port memory request bus to NUM_CH
// streaming channels that feed AOS accelerator cores.
//
// Each channel has four word registers. The word address is split as
// {channel, register}:
//   reg 0 DATA      : write pushes {wdata, be, last=0}; read returns RES and clears res_vld
//   reg 1 DATA_LAST : write pushes {wdata, be, last=1}; read returns RES
//   reg 2 STATUS    : {count[15:8], res_vld[3], overflow[2], full[1], empty[0]}
//   reg 3 CTRL      : write bit0 = flush FIFO, bit1 = clear overflow; reads 0
// Accesses to a channel index >= NUM_CH are granted, have no effect and read 0.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   mem_req_i/we/addr/be/wdata   request side of the memory bus
//   mem_gnt_o                    request accepted this cycle (combinational)
//   mem_rvalid_o/rdata_o         registered response, one cycle after each grant
//   strm_valid/ready/data/keep/last  per-channel FIFO head, channel c at slice c
//   res_valid_i/res_data_i       per-channel result capture
//
// Build option: `define AOS_BRIDGE_STALL_EN to withhold grant from a DATA or
// DATA_LAST write to a full FIFO instead of dropping the word and flagging
// overflow. STATUS needs DATA_WIDTH >= 16.

module aos_m2s_ch #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic [DW/8-1:0] push_be,
  input  logic          push_last,
  input  logic          flush,
  input  logic          clr_ovf,
  input  logic          res_rd_clr,
  input  logic          strm_ready,
  input  logic          res_valid,
  input  logic [DW-1:0] res_data,
  output logic          strm_valid,
  output logic [DW-1:0] strm_data,
  output logic [DW/8-1:0] strm_keep,
  output logic          strm_last,
  output logic [DW-1:0] status,
  output logic [DW-1:0] res
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] keep;
    logic            last;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ovf, res_vld, empty, full, pop, wr;
  logic [15:0]   st;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = !empty && strm_ready;
  // Fullness is judged before this cycle's pop, so a push racing a pop on a
  // full FIFO is treated as a push to a full FIFO.
  assign wr    = push && !full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      res_vld <= 1'b0;
      res     <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr)  wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({wr, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
      if (clr_ovf)          ovf <= 1'b0;
      else if (push && full) ovf <= 1'b1;
      // A capture coinciding with a clearing read keeps res_vld set.
      if (res_valid) begin
        res     <= res_data;
        res_vld <= 1'b1;
      end else if (res_rd_clr) begin
        res_vld <= 1'b0;
      end
    end
  end

  // Storage needs no reset: the head outputs are gated by valid.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= '{data: push_data, keep: push_be, last: push_last};
  end

  assign head       = mem[rd_ptr];
  assign strm_valid = !empty;
  assign strm_data  = strm_valid ? head.data : '0;
  assign strm_keep  = strm_valid ? head.keep : '0;
  assign strm_last  = strm_valid && head.last;

  assign st     = {8'(count), 4'b0, res_vld, ovf, full, empty};
  assign status = DW'(st);
endmodule

module aos_mem2strm #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mem_req_i,
  output logic                           mem_gnt_o,
  input  logic                           mem_we_i,
  input  logic [ADDR_WIDTH-1:0]          mem_addr_i,
  input  logic [DATA_WIDTH/8-1:0]        mem_be_i,
  input  logic [DATA_WIDTH-1:0]          mem_wdata_i,
  output logic                           mem_rvalid_o,
  output logic [DATA_WIDTH-1:0]          mem_rdata_o,
  output logic [NUM_CH-1:0]              strm_valid_o,
  input  logic [NUM_CH-1:0]              strm_ready_i,
  output logic [NUM_CH*DATA_WIDTH-1:0]   strm_data_o,
  output logic [NUM_CH*DATA_WIDTH/8-1:0] strm_keep_o,
  output logic [NUM_CH-1:0]              strm_last_o,
  input  logic [NUM_CH-1:0]              res_valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   res_data_i
);
  localparam int CHW = ADDR_WIDTH - 2;
  localparam int BW  = DATA_WIDTH / 8;

  logic [CHW-1:0]                        sel_ch;
  logic [1:0]                            sel_reg;
  logic                                  ch_ok, acc, stall;
  logic [NUM_CH-1:0]                     hit;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]     ch_status, ch_res;
  logic [DATA_WIDTH-1:0]                 rdata_d;

  assign sel_ch  = mem_addr_i[ADDR_WIDTH-1:2];
  assign sel_reg = mem_addr_i[1:0];
  assign ch_ok   = int'(sel_ch) < NUM_CH;

  always_comb begin
    hit     = '0;
    stall   = 1'b0;
    rdata_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_ok && sel_ch == CHW'(c)) begin
        hit[c] = 1'b1;
`ifdef AOS_BRIDGE_STALL_EN
        // STATUS bit 1 is the channel's full flag.
        if (mem_req_i && mem_we_i && !sel_reg[1] && ch_status[c][1]) stall = 1'b1;
`endif
        case (sel_reg)
          2'd0, 2'd1: rdata_d = ch_res[c];
          2'd2:       rdata_d = ch_status[c];
          default:    ;
        endcase
      end
    end
  end

  assign mem_gnt_o = !rst && !stall;
  assign acc       = mem_req_i && mem_gnt_o;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    aos_m2s_ch #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .push       (acc && hit[c] && mem_we_i && !sel_reg[1]),
      .push_data  (mem_wdata_i),
      .push_be    (mem_be_i),
      .push_last  (sel_reg[0]),
      .flush      (acc && hit[c] && mem_we_i && sel_reg == 2'd3 && mem_wdata_i[0]),
      .clr_ovf    (acc && hit[c] && mem_we_i && sel_reg == 2'd3 && mem_wdata_i[1]),
      .res_rd_clr (acc && hit[c] && !mem_we_i && sel_reg == 2'd0),
      .strm_ready (strm_ready_i[c]),
      .res_valid  (res_valid_i[c]),
      .res_data   (res_data_i[c*DATA_WIDTH +: DATA_WIDTH]),
      .strm_valid (strm_valid_o[c]),
      .strm_data  (strm_data_o[c*DATA_WIDTH +: DATA_WIDTH]),
      .strm_keep  (strm_keep_o[c*BW +: BW]),
      .strm_last  (strm_last_o[c]),
      .status     (ch_status[c]),
      .res        (ch_res[c])
    );
  end

  // Every granted request gets exactly one response; writes answer with 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rvalid_o <= 1'b0;
      mem_rdata_o  <= '0;
    end else begin
      mem_rvalid_o <= acc;
      mem_rdata_o  <= (acc && !mem_we_i) ? rdata_d : '0;
    end
  end
endmodule

// File: tb/tb_aos_mem2strm.sv
module tb_aos_mem2strm;
  logic        clk, rst;
  logic        mem_req_i, mem_gnt_o, mem_we_i, mem_rvalid_o;
  logic [5:0]  mem_addr_i;
  logic [3:0]  mem_be_i;
  logic [31:0] mem_wdata_i, mem_rdata_o;
  logic [1:0]  strm_valid_o, strm_ready_i, strm_last_o, res_valid_i;
  logic [63:0] strm_data_o, res_data_i;
  logic [7:0]  strm_keep_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] rdq [$];        // expected response data, one per grant
  logic [36:0] sq  [2][$];     // expected stream words {data, keep, last}
  logic [36:0] mon_e;

  aos_mem2strm dut (
    .clk(clk), .rst(rst),
    .mem_req_i(mem_req_i), .mem_gnt_o(mem_gnt_o), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_be_i(mem_be_i), .mem_wdata_i(mem_wdata_i),
    .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o),
    .strm_valid_o(strm_valid_o), .strm_ready_i(strm_ready_i),
    .strm_data_o(strm_data_o), .strm_keep_o(strm_keep_o), .strm_last_o(strm_last_o),
    .res_valid_i(res_valid_i), .res_data_i(res_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumer: stream pops and bus responses.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        if (strm_valid_o[c] && strm_ready_i[c]) begin
          total++;
          if (sq[c].size() == 0) begin
            bad++;
            $display("FAIL strm%0d_unexpected got=%h", c, strm_data_o[c*32 +: 32]);
          end else begin
            mon_e = sq[c].pop_front();
            if ({strm_data_o[c*32 +: 32], strm_keep_o[c*4 +: 4], strm_last_o[c]} !== mon_e) begin
              bad++;
              $display("FAIL strm%0d_word got=%h/%h/%b want=%h", c, strm_data_o[c*32 +: 32],
                       strm_keep_o[c*4 +: 4], strm_last_o[c], mon_e);
            end
          end
        end
      end
      if (mem_rvalid_o) begin
        total++;
        if (rdq.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected got=%h", mem_rdata_o);
        end else if (mem_rdata_o !== rdq[0]) begin
          bad++;
          $display("FAIL rsp_data got=%h want=%h", mem_rdata_o, rdq[0]);
          void'(rdq.pop_front());
        end else begin
          void'(rdq.pop_front());
        end
      end
    end
  end

  // Issue one request at posedge+1, wait (bounded) for grant, return at posedge+1.
  task automatic bus(input logic we, input logic [5:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_push);
    int n = 0;
    int ch = int'(a[5:2]);
    mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = a; mem_wdata_i = d; mem_be_i = 4'hF;
    @(negedge clk);
    while (!mem_gnt_o && n < 40) begin n++; @(negedge clk); end
    if (!mem_gnt_o) begin
      total++; bad++;
      $display("FAIL gnt_timeout addr=%h got=0 want=1", a);
    end else begin
      rdq.push_back(we ? 32'h0 : exp_rd);
      if (exp_push && ch < 2) sq[ch].push_back({d, 4'hF, a[0]});
    end
    @(posedge clk); #1;
    mem_req_i = 1'b0; mem_we_i = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic exp_push);
    bus(1'b1, a, d, 32'h0, exp_push);
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp_rd);
    bus(1'b0, a, 32'h0, exp_rd, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while ((sq[0].size() != 0 || sq[1].size() != 0) && n < 50) begin n++; @(negedge clk); end
    total++;
    if (sq[0].size() != 0 || sq[1].size() != 0) begin
      bad++;
      $display("FAIL drain_timeout left=%0d/%0d want=0/0", sq[0].size(), sq[1].size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({mem_gnt_o, mem_rvalid_o, strm_valid_o, strm_last_o} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=0", {mem_gnt_o, mem_rvalid_o, strm_valid_o, strm_last_o});
    end
    total++;
    if ({mem_rdata_o, strm_data_o, strm_keep_o} !== '0) begin
      bad++; $display("FAIL reset_data got=%h want=0", {mem_rdata_o, strm_data_o, strm_keep_o});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++;
    if (mem_gnt_o !== 1'b1) begin bad++; $display("FAIL gnt_after_reset got=%b want=1", mem_gnt_o); end
    @(posedge clk); #1;
    rd(6'd2, 32'h0001);
    rd(6'd0, 32'h0);
  endtask

  task automatic test_basic();
    strm_ready_i = 2'b00;
    wr(6'd0, 32'hA5A5_0001, 1'b1);
    total++;
    if ({strm_valid_o[0], strm_data_o[31:0], strm_keep_o[3:0], strm_last_o[0]} !== {1'b1, 32'hA5A5_0001, 4'hF, 1'b0}) begin
      bad++; $display("FAIL basic_head got=%b/%h/%h/%b want=1/a5a50001/f/0", strm_valid_o[0],
                      strm_data_o[31:0], strm_keep_o[3:0], strm_last_o[0]);
    end
    rd(6'd2, 32'h0100);
    strm_ready_i = 2'b01;
    drain();
    strm_ready_i = 2'b00;
  endtask

  task automatic test_last();
    wr(6'd4, 32'h11, 1'b1);
    wr(6'd5, 32'h22, 1'b1);
    strm_ready_i = 2'b10;
    @(negedge clk);
    total++;
    if ({strm_data_o[63:32], strm_last_o[1]} !== {32'h11, 1'b0}) begin
      bad++; $display("FAIL last_first got=%h/%b want=11/0", strm_data_o[63:32], strm_last_o[1]);
    end
    @(negedge clk);
    total++;
    if ({strm_data_o[63:32], strm_last_o[1]} !== {32'h22, 1'b1}) begin
      bad++; $display("FAIL last_second got=%h/%b want=22/1", strm_data_o[63:32], strm_last_o[1]);
    end
    @(negedge clk);
    total++;
    if (strm_valid_o[1] !== 1'b0) begin bad++; $display("FAIL last_empty got=%b want=0", strm_valid_o[1]); end
    @(posedge clk); #1;
    strm_ready_i = 2'b00;
    rd(6'd6, 32'h0001);
  endtask

  task automatic test_full();
    strm_ready_i = 2'b00;
    for (int i = 0; i < 4; i++) wr(6'd0, 32'h100 + i, 1'b1);
`ifdef AOS_BRIDGE_STALL_EN
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 6'd0; mem_wdata_i = 32'h104; mem_be_i = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (mem_gnt_o !== 1'b0) begin bad++; $display("FAIL stall_gnt got=%b want=0", mem_gnt_o); end
    end
    @(posedge clk); #1;
    strm_ready_i = 2'b01;
    @(posedge clk); #1;
    strm_ready_i = 2'b00;
    wr(6'd0, 32'h104, 1'b1);
    rd(6'd2, 32'h0402);
    total++;
    if (strm_data_o[31:0] !== 32'h101) begin bad++; $display("FAIL stall_head got=%h want=101", strm_data_o[31:0]); end
`else
    wr(6'd0, 32'h104, 1'b0);
    rd(6'd2, 32'h0406);
    total++;
    if (strm_data_o[31:0] !== 32'h100) begin bad++; $display("FAIL full_head got=%h want=100", strm_data_o[31:0]); end
    wr(6'd3, 32'h2, 1'b0);
    rd(6'd2, 32'h0402);
`endif
    strm_ready_i = 2'b01;
    drain();
    strm_ready_i = 2'b00;
    rd(6'd2, 32'h0001);
  endtask

  task automatic test_result();
    res_valid_i = 2'b10; res_data_i = {32'hDEAD_BEEF, 32'h0};
    @(posedge clk); #1;
    res_valid_i = 2'b00;
    rd(6'd6, 32'h0009);
    rd(6'd5, 32'hDEAD_BEEF);
    rd(6'd6, 32'h0009);
    rd(6'd4, 32'hDEAD_BEEF);
    rd(6'd6, 32'h0001);
    rd(6'd0, 32'h0);
    // capture colliding with a clearing read
    res_valid_i = 2'b10; res_data_i = {32'h0000_AAAA, 32'h0};
    @(posedge clk); #1;
    res_data_i = {32'h0000_BBBB, 32'h0};
    rd(6'd4, 32'h0000_AAAA);
    res_valid_i = 2'b00;
    rd(6'd6, 32'h0009);
    rd(6'd4, 32'h0000_BBBB);
    rd(6'd6, 32'h0001);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) wr(6'd0, 32'h200 + i, 1'b1);
    strm_ready_i = 2'b01;
    wr(6'd3, 32'h1, 1'b0);
    sq[0].delete();
    total++;
    if (strm_valid_o[0] !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", strm_valid_o[0]); end
    strm_ready_i = 2'b00;
    rd(6'd2, 32'h0001);
    wr(6'd0, 32'h300, 1'b1);
    strm_ready_i = 2'b01;
    drain();
    strm_ready_i = 2'b00;
  endtask

  task automatic test_decode();
    wr(6'd8, 32'h55, 1'b0);
    total++;
    if (strm_valid_o !== 2'b00) begin bad++; $display("FAIL decode_push got=%b want=00", strm_valid_o); end
    rd(6'd8, 32'h0);
    rd(6'd10, 32'h0);
    rd(6'h3F, 32'h0);
  endtask

  task automatic test_back_to_back();
    strm_ready_i = 2'b11;
    for (int i = 0; i < 8; i++) wr((i % 2) ? 6'd5 : 6'd0, 32'h400 + i, 1'b1);
    drain();
    strm_ready_i = 2'b00;
  endtask

  task automatic test_reset_mid();
    wr(6'd0, 32'h500, 1'b1);
    wr(6'd0, 32'h501, 1'b1);
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 6'd0; mem_wdata_i = 32'h502;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_req_i = 1'b0; mem_we_i = 1'b0;
    sq[0].delete();
    #1;
    total++;
    if ({mem_gnt_o, mem_rvalid_o, strm_valid_o, strm_last_o} !== 6'b0) begin
      bad++; $display("FAIL rstmid_flags got=%b want=0", {mem_gnt_o, mem_rvalid_o, strm_valid_o, strm_last_o});
    end
    total++;
    if ({mem_rdata_o, strm_data_o, strm_keep_o} !== '0) begin
      bad++; $display("FAIL rstmid_data got=%h want=0", {mem_rdata_o, strm_data_o, strm_keep_o});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rd(6'd2, 32'h0001);
  endtask

  initial begin
    rst = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_be_i = '0;
    mem_wdata_i = '0; strm_ready_i = '0; res_valid_i = '0; res_data_i = '0;
    test_reset();
    test_basic();
    test_last();
    test_full();
    test_result();
    test_flush();
    test_decode();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (rdq.size() != 0) begin bad++; $display("FAIL rsp_missing got=%0d want=0", rdq.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
